// File: rtl/jmb_scanline_filter_n.sv
// N-tap horizontal scanline FIR with valid/ready handshakes, per-line edge padding,
// rounding and saturation. One output per input pixel; tail outputs come from FLUSH pads.

module jmb_sf_tap #(
  parameter int PIXEL_W = 8,
  parameter int COEF_W  = 8
) (
  input  logic        [PIXEL_W-1:0]      pix,
  input  logic signed [COEF_W-1:0]       coef,
  output logic signed [PIXEL_W+COEF_W:0] prod
);
  assign prod = $signed({1'b0, pix}) * coef;
endmodule

module jmb_scanline_filter_n #(
  parameter int PIXEL_W = 8,
  parameter int COEF_W  = 8,
  parameter int TAPS    = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     filter_en,
  input  logic                     edge_mode,
  input  logic [3:0]               shift,
  input  logic [TAPS*COEF_W-1:0]   coefs,
  input  logic [PIXEL_W-1:0]       in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [PIXEL_W-1:0]       out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready
);
  localparam int H     = (TAPS - 1) / 2;
  localparam int ACC_W = PIXEL_W + COEF_W + $clog2(TAPS) + 1;
  localparam int CW    = $clog2(TAPS) + 1;
  localparam int STAGES = 2;
  localparam logic signed [ACC_W-1:0] PMAX = $signed({{(ACC_W-PIXEL_W){1'b0}}, {PIXEL_W{1'b1}}});

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                       state;
  logic [CW-1:0]                cnt, fcnt;
  logic [TAPS-1:0][PIXEL_W-1:0] win;
  logic                         filt_l, edge_l;
  logic [3:0]                   shift_l;
  logic [TAPS*COEF_W-1:0]       coefs_l;
  logic [STAGES:0]              vld_pipe, lst_pipe;
  logic signed [ACC_W-1:0]      acc_q, acc_d, sum, rnd;
  logic signed [PIXEL_W+COEF_W:0] prod [TAPS];
  logic [PIXEL_W-1:0]           pad, sat_d;
  logic                         advance, accept, flush_step, inject, emit, fin;

  assign advance    = enable & ~(out_valid & ~out_ready);
  assign in_ready   = advance & ~reset & (state != FLUSH);
  assign accept     = in_valid & in_ready;
  assign flush_step = advance & (state == FLUSH);
  assign inject     = accept | flush_step;
  // A sample completes a window once H samples of the line precede it.
  assign emit       = (cnt >= CW'(H));
  assign fin        = flush_step & (fcnt == CW'(H - 1));
  assign pad        = edge_l ? win[TAPS-1] : '0;
  assign out_valid  = vld_pipe[STAGES];
  assign out_last   = lst_pipe[STAGES];

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    jmb_sf_tap #(.PIXEL_W(PIXEL_W), .COEF_W(COEF_W)) u_tap (
      .pix  (win[k]),
      .coef (coefs_l[k*COEF_W +: COEF_W]),
      .prod (prod[k])
    );
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) sum = sum + ACC_W'(prod[k]);
    rnd   = (shift_l == 4'd0) ? '0 : (ACC_W'(1) << (shift_l - 4'd1));
    acc_d = filt_l ? ((sum + rnd) >>> shift_l)
                   : $signed({{(ACC_W-PIXEL_W){1'b0}}, win[H]});
    if (acc_q < 0)         sat_d = '0;
    else if (acc_q > PMAX) sat_d = '1;
    else                   sat_d = acc_q[PIXEL_W-1:0];
  end

  // Datapath: window shift, line parameters latched on p0, accumulate stage.
  always_ff @(posedge clock) begin
    if (accept && state == IDLE) begin
      filt_l  <= filter_en;
      edge_l  <= edge_mode;
      shift_l <= shift;
      coefs_l <= coefs;
      for (int k = 0; k < TAPS - 1; k++) win[k] <= edge_mode ? in_data : '0;
      win[TAPS-1] <= in_data;
    end else if (accept) begin
      win <= {in_data, win[TAPS-1:1]};
    end else if (flush_step) begin
      win <= {pad, win[TAPS-1:1]};
    end
    if (advance) acc_q <= acc_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      fcnt     <= '0;
      vld_pipe <= '0;
      lst_pipe <= '0;
      out_data <= '0;
    end else begin
      if (advance) begin
        vld_pipe <= {vld_pipe[STAGES-1:0], inject & emit};
        lst_pipe <= {lst_pipe[STAGES-1:0], fin};
        if (vld_pipe[STAGES-1]) out_data <= sat_d;
      end
      case (state)
        IDLE: if (accept) begin
          cnt   <= CW'(1);
          fcnt  <= '0;
          state <= in_last ? FLUSH : RUN;
        end
        RUN: if (accept) begin
          if (!emit) cnt <= cnt + CW'(1);
          if (in_last) state <= FLUSH;
        end
        FLUSH: if (flush_step) begin
          if (!emit) cnt <= cnt + CW'(1);
          fcnt <= fcnt + CW'(1);
          if (fin) begin
            state <= IDLE;
            cnt   <= '0;
            fcnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jmb_scanline_filter_n.sv
// Bench for jmb_scanline_filter_n (TAPS=3): line-level reference model with a per-cycle
// output compare, plus literal expectations for the directed lines.

module tb_jmb_scanline_filter_n;
  logic        clock = 0;
  logic        reset, enable, filter_en, edge_mode, out_ready;
  logic [3:0]  shift;
  logic [23:0] coefs;
  logic [7:0]  in_data, out_data;
  logic        in_valid, in_last, in_ready, out_valid, out_last;

  jmb_scanline_filter_n #(.PIXEL_W(8), .COEF_W(8), .TAPS(3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .filter_en(filter_en),
    .edge_mode(edge_mode), .shift(shift), .coefs(coefs), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int pass_cnt = 0, chk_cnt = 0;
  int exp_d[$]; bit exp_l[$];
  int got_d[$]; bit got_l[$];
  int acc_cyc[64];
  int first_vld = -1;
  bit rand_stall = 0;

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic note_fail(input string nm);
    chk_cnt++;
    $display("FAIL %s", nm);
  endtask

  // Reference: y_i = sat(round(sum c_k * p(i-1+k)) >>> sh) with padded/clamped edges.
  function automatic void model_line(input int px[$], input int c0, input int c1, input int c2,
                                     input int sh, input bit edg, input bit filt);
    int c[3];
    int n = px.size();
    c[0] = c0; c[1] = c1; c[2] = c2;
    for (int i = 0; i < n; i++) begin
      int v, s, p, idx;
      if (!filt) v = px[i];
      else begin
        s = 0;
        for (int k = 0; k < 3; k++) begin
          idx = i - 1 + k;
          if (idx < 0)       p = edg ? px[0] : 0;
          else if (idx >= n) p = edg ? px[n-1] : 0;
          else               p = px[idx];
          s += c[k] * p;
        end
        if (sh > 0) s += 1 << (sh - 1);
        v = s >>> sh;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
      end
      exp_d.push_back(v);
      exp_l.push_back(i == n - 1);
    end
  endfunction

  task automatic knobs();
    if (rand_stall) begin
      enable    = ($urandom_range(3) != 0);
      out_ready = enable && ($urandom_range(2) != 0);
    end else begin
      enable = 1; out_ready = 1;
    end
  endtask

  task automatic send_line(input int px[$], input int c0, input int c1, input int c2,
                           input int sh, input bit edg, input bit filt, input bit lst, input bit scr);
    if (lst) model_line(px, c0, c1, c2, sh, edg, filt);
    for (int i = 0; i < px.size(); i++) begin
      bit acc = 0;
      int tries = 0;
      while (!acc) begin
        @(negedge clock);
        knobs();
        if (i == 0) begin
          coefs = {8'(c2), 8'(c1), 8'(c0)};
          shift = 4'(sh); edge_mode = edg; filter_en = filt;
        end else if (scr) begin
          coefs = 24'($urandom); shift = 4'($urandom_range(15));
          edge_mode = 1'($urandom_range(1)); filter_en = 1'($urandom_range(1));
        end
        in_valid = 1; in_data = 8'(px[i]); in_last = lst && (i == px.size() - 1);
        #1;
        acc = in_ready;
        if (acc) acc_cyc[i] = cyc;
        @(posedge clock);
        tries++;
        if (!acc && tries > 200) begin
          note_fail("accept_timeout");
          return;
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_d.size() > 0 && n < 400) begin
      @(negedge clock);
      knobs(); in_valid = 0; in_last = 0;
      n++;
    end
    rand_stall = 0;
    repeat (4) begin
      @(negedge clock);
      knobs(); in_valid = 0; in_last = 0;
    end
    chk("drain_left", exp_d.size(), 0);
  endtask

  task automatic check_got(input string nm, input int lit[$]);
    chk({nm, "_count"}, got_d.size(), lit.size());
    for (int i = 0; i < lit.size() && i < got_d.size(); i++) chk(nm, got_d[i], lit[i]);
  endtask

  task automatic start_test();
    got_d.delete(); got_l.delete(); first_vld = -1;
  endtask

  // Per-cycle compare, sampled after the driver settles its negedge inputs.
  bit stalled = 0;
  int st_d; bit st_l;
  always @(negedge clock) begin
    #2;
    if (reset) stalled = 0;
    else begin
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, st_d);
        chk("stall_last", out_last, st_l);
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_out: got data %0d, expected no output", out_data);
        end else begin
          chk("out_data", out_data, exp_d.pop_front());
          chk("out_last", out_last, exp_l.pop_front());
        end
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      stalled = out_valid && !out_ready;
      st_d = out_data; st_l = out_last;
    end
  end

  initial begin
    int px[$];
    reset = 1; enable = 1; out_ready = 1; in_valid = 0; in_last = 0; in_data = 0;
    filter_en = 1; edge_mode = 0; shift = 0; coefs = 0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 0;

    // Zero-pad ramp, with first-output latency.
    start_test();
    send_line('{1, 2, 3, 4, 5}, 1, 2, 1, 2, 0, 1, 1, 0);
    drain();
    check_got("zero_ramp", '{1, 2, 3, 4, 4});
    for (int i = 0; i < 5; i++) chk("zero_ramp_last", got_l.size() > i ? int'(got_l[i]) : -1, (i == 4) ? 1 : 0);
    // accept taken at edge k (cyc==k at sample) -> out_valid set by edge k+2 -> seen with cyc==k+3
    chk("latency", first_vld - acc_cyc[1], 3);

    start_test();
    send_line('{1, 2, 3, 4, 5}, 1, 2, 1, 2, 1, 1, 1, 0);
    drain();
    check_got("repl_ramp", '{1, 2, 3, 4, 5});

    start_test();
    send_line('{100}, 0, 4, 0, 0, 0, 1, 1, 0);
    drain();
    send_line('{10}, 0, -1, 0, 0, 0, 1, 1, 0);
    drain();
    check_got("saturate", '{255, 0});

    // Single-pixel line: one FLUSH cycle with in_ready low.
    start_test();
    send_line('{200}, 1, 2, 1, 2, 0, 1, 1, 0);
    @(negedge clock); knobs(); in_valid = 0; in_last = 0; #1;
    chk("flush_ready_low", in_ready, 0);
    @(negedge clock); knobs(); #1;
    chk("flush_ready_back", in_ready, 1);
    drain();
    check_got("single_zero", '{100});
    chk("single_zero_last", got_l.size() > 0 ? int'(got_l[0]) : -1, 1);
    start_test();
    send_line('{200}, 1, 2, 1, 2, 1, 1, 1, 0);
    drain();
    check_got("single_repl", '{200});

    start_test();
    send_line('{7, 8, 9}, 1, 2, 1, 2, 0, 0, 1, 0);
    drain();
    check_got("bypass", '{7, 8, 9});

    // Reset after the 2nd pixel discards the partial line.
    start_test();
    send_line('{50, 60}, 1, 2, 1, 2, 0, 1, 0, 0);
    @(negedge clock); in_valid = 0; reset = 1;
    @(negedge clock); reset = 0; #1;
    chk("reset_out_valid", out_valid, 0);
    exp_d.delete(); exp_l.delete();
    send_line('{10, 20, 30}, 1, 2, 1, 2, 0, 1, 1, 0);
    drain();
    check_got("after_reset", '{10, 20, 20});

    // Three back-to-back 16-pixel lines under random stalls and enable gaps.
    start_test();
    rand_stall = 1;
    px.delete();
    for (int i = 0; i < 16; i++) px.push_back($urandom_range(255));
    send_line(px, 1, 2, 1, 2, 0, 1, 1, 0);
    px.delete();
    for (int i = 0; i < 16; i++) px.push_back($urandom_range(255));
    send_line(px, -1, 6, -1, 2, 1, 1, 1, 1);
    px.delete();
    for (int i = 0; i < 16; i++) px.push_back($urandom_range(255));
    send_line(px, 3, -2, 5, 1, 0, 1, 1, 0);
    drain();
    chk("stress_count", got_d.size(), 48);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/jmb_scanline_filter_n.md
# jmb_scanline_filter_n

Parametrised N-tap horizontal FIR filter for 8-bit-class pixel scanlines. It is the next generation of the fixed 3-tap `jmb_scanline_filter` and sits in the same pixel path, between the line source and the frame writer. It adds four things the 3-tap block lacks:
- generic tap count and widths;
- valid/ready handshakes on both sides;
- per-line edge handling (zero-pad or replicate) with exactly one output per input pixel;
- rounding and saturation.

## Interface
- PIXEL_W, 8, pixel width (unsigned).
- COEF_W, 8, coefficient width (signed two's complement).
- TAPS, 3, tap count; odd, 3..9. H = (TAPS-1)/2.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- enable  in  1  global clock-enable; 0 freezes all state, outputs held.
- filter_en  in  1  1 = filter, 0 = bypass (centre pixel out, same latency).
- edge_mode  in  1  0 = zero-pad, 1 = replicate edge pixel.
- shift  in  4  right-shift amount 0..15 applied to the sum.
- coefs  in  TAPS*COEF_W  tap k at bits [k*COEF_W +: COEF_W]; tap 0 multiplies the oldest pixel.
- in_data  in  PIXEL_W  input pixel.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the last pixel of a scanline.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  PIXEL_W  filtered pixel.
- out_valid  out  1  out_data valid.
- out_last  out  1  last output pixel of the line.
- out_ready  in  1  downstream accepts out_data.

## Operation
- Line of length L (p0..pL-1) produces exactly L outputs y0..yL-1.
- Filter equation: yi = sat(round(sum over k of c_k * p(i-H+k)) >>> shift).
  - Out-of-range p index reads 0 in zero mode.
  - Out-of-range p index reads p0 / pL-1 (clamped) in replicate mode.
- filter_en, edge_mode, shift and coefs are sampled when p0 is accepted and held for the whole line. Mid-line changes are ignored.
- FSM states and transitions:
  - IDLE → RUN on the first accept.
  - RUN → FLUSH on accept with in_last.
  - FLUSH injects H internal pad samples, one per advance, with in_ready = 0.
  - FLUSH → IDLE after the last pad sample.
  - L ≤ H is legal: FLUSH still emits all L outputs, no more and no fewer.
- Window preload: on p0 accept, older window slots are filled with the pad value (0, or p0 in replicate mode).
- Arithmetic:
  - Pixel is zero-extended to PIXEL_W+1 signed; product is signed.
  - Accumulator is PIXEL_W+COEF_W+clog2(TAPS)+1 bits.
  - Rounding: add 1<<(shift-1) when shift > 0, then arithmetic right shift.
  - Saturate: < 0 → 0; > 2^PIXEL_W-1 → 2^PIXEL_W-1.
- Bypass: out_data = centre pixel p(i), no arithmetic; ordering and out_last are the same as in filter mode.
- out_last is asserted on y(L-1) only.

## Timing
- advance = enable & !(out_valid & !out_ready).
- in_ready = advance & !reset & (state != FLUSH).
- Pipeline: window reg → accumulate reg → output reg.
- Latency: with no stall, yi appears (out_valid = 1) 2 cycles after the accept of p(i+H), or after the corresponding FLUSH slot.
- Stall: while out_valid & !out_ready, the whole pipeline holds and out_data / out_last stay stable. There is no drop and no duplicate.
- enable = 0 behaves as a full stall, with in_ready = 0.
- Back-to-back lines: the next line's p0 is accepted in the first cycle after FLUSH ends. Windows never mix lines.
- Simultaneous in_last and out stall: the accept is not taken (in_ready = 0); in_last is re-presented by the source.
- Reset values: out_valid = 0, out_last = 0, out_data = 0, in_ready = 0, state = IDLE, all stage valids = 0.
- Reset mid-line: the partial line is discarded entirely. The next accepted pixel is treated as p0 of a new line.

## Test plan
- **Zero-pad ramp.** TAPS = 3, coefs (1,2,1), shift 2, edge_mode 0, line 1,2,3,4,5 (last on 5) → 1,2,3,4,4; out_last only on the 5th output. First out_valid is exactly 2 cycles after the accept of 2.
- **Replicate ramp.** Same as the zero-pad ramp with edge_mode 1 → 1,2,3,4,5.
- **Saturation.** coefs (0,4,0), shift 0, input 100 → 255. coefs (0,-1,0), input 10 → 0.
- **Single-pixel line.** Input 200 with in_last, coefs (1,2,1), shift 2:
  - zero mode → 100, out_last = 1;
  - replicate mode → 200;
  - in_ready is 0 for exactly H = 1 cycle after the accept.
- **Backpressure and enable.** Random out_ready and enable gaps over three back-to-back 16-pixel lines → output stream identical to the unstalled run; out_data stable while stalled; lines are not mixed.
- **Bypass and reset.** filter_en = 0 with input 7,8,9 → 7,8,9. Reset asserted after the 2nd pixel of a line → out_valid = 0 on the next cycle. The following line 10,20,30 under (1,2,1)/2, zero mode → 10,20,20.
